// File: rtl/pixel_filter_engine.sv
// pixel_filter_engine
//   Streams num_pix pixels from a synchronous-read source RAM through one of
//   four per-pixel filters into a destination RAM. Each pixel takes four
//   cycles: READ (address out), WAIT (RAM latency, capture), FILTER (register
//   result), WRITE (one-cycle write strobe).
//
// Ports
//   clk           clock, rising edge
//   reset         asynchronous, active-high reset
//   start_i       job request, sampled only while idle
//   abort_i       synchronous cancel of a running job
//   mode_i        00 copy, 01 gray, 10 invert, 11 threshold
//   threshold_i   threshold level for mode 11
//   num_pix_i     pixel count, 0 .. 2**ADDR_BITS
//   src_addr_o    source RAM read address
//   src_rdata_i   source RAM read data (1-cycle latency)
//   dst_addr_o    destination RAM write address
//   dst_we_o      destination write enable
//   dst_wdata_o   filtered pixel
//   busy_o        high whenever not idle
//   done_o        one-cycle completion pulse
//   pix_count_o   pixels written in the current or last job
//   last_gray_o   gray value of the most recently written source pixel
module pixel_filter_engine #(
   parameter int ADDR_BITS = 10,
   parameter int CH_W      = 8,
   localparam int PIX_W    = 3 * CH_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [1:0]           mode_i,
   input  logic [CH_W-1:0]      threshold_i,
   input  logic [ADDR_BITS:0]   num_pix_i,
   output logic [ADDR_BITS-1:0] src_addr_o,
   input  logic [PIX_W-1:0]     src_rdata_i,
   output logic [ADDR_BITS-1:0] dst_addr_o,
   output logic                 dst_we_o,
   output logic [PIX_W-1:0]     dst_wdata_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [ADDR_BITS:0]   pix_count_o,
   output logic [CH_W-1:0]      last_gray_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_WAIT, S_FILTER, S_WRITE, S_DONE
   } state_t;

   localparam logic [ADDR_BITS:0] ONE    = (ADDR_BITS+1)'(1);
   localparam logic [CH_W+1:0]    THREE  = (CH_W+2)'(3);

   state_t               state_q, state_d;
   // One bit wider than the address so a full 2**ADDR_BITS job never wraps.
   logic [ADDR_BITS:0]   index_q, index_d;
   logic [ADDR_BITS:0]   pix_count_q, pix_count_d;
   logic [ADDR_BITS:0]   num_pix_q, num_pix_d;
   logic [CH_W-1:0]      last_gray_q, last_gray_d;
   logic [CH_W-1:0]      thr_q, thr_d;
   logic [1:0]           mode_q, mode_d;
   logic [PIX_W-1:0]     pix_q, pix_d;
   logic [PIX_W-1:0]     result_q, result_d;

   // ---------------- filter datapath (combinational from pix_q) ----------
   logic [CH_W+1:0]      sum;
   logic [CH_W-1:0]      gray;
   logic [PIX_W-1:0]     inv_pix;
   logic [PIX_W-1:0]     filt;

   // (2**CH_W-1) - x is simply the bitwise complement of x.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_inv
         assign inv_pix[gi*CH_W +: CH_W] = ~pix_q[gi*CH_W +: CH_W];
      end
   endgenerate

   always_comb begin
      sum  = {2'b00, pix_q[3*CH_W-1:2*CH_W]}
           + {2'b00, pix_q[2*CH_W-1:CH_W]}
           + {2'b00, pix_q[CH_W-1:0]};
      // Max sum/3 is 2**CH_W-1, so the truncation never loses information.
      gray = CH_W'(sum / THREE);
      case (mode_q)
         2'b00:   filt = pix_q;
         2'b01:   filt = {3{gray}};
         2'b10:   filt = inv_pix;
         default: filt = (gray >= thr_q) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
      endcase
   end

   // ---------------- control FSM ------------------------------------------
   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      pix_count_d = pix_count_q;
      num_pix_d   = num_pix_q;
      last_gray_d = last_gray_q;
      thr_d       = thr_q;
      mode_d      = mode_q;
      pix_d       = pix_q;
      result_d    = result_q;
      dst_we_o    = 1'b0;
      done_o      = 1'b0;

      if (abort_i && (state_q != S_IDLE)) begin
         // Cancel wins over every transition; no strobe, no done, counts hold.
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  mode_d      = mode_i;
                  thr_d       = threshold_i;
                  num_pix_d   = num_pix_i;
                  index_d     = '0;
                  pix_count_d = '0;
                  state_d     = (num_pix_i == '0) ? S_DONE : S_READ;
               end
            end
            S_READ:   state_d = S_WAIT;
            S_WAIT: begin
               pix_d   = src_rdata_i;
               state_d = S_FILTER;
            end
            S_FILTER: begin
               result_d = filt;
               state_d  = S_WRITE;
            end
            S_WRITE: begin
               dst_we_o    = 1'b1;
               pix_count_d = pix_count_q + ONE;
               index_d     = index_q + ONE;
               last_gray_d = gray;
               state_d     = (index_q == num_pix_q - ONE) ? S_DONE : S_READ;
            end
            S_DONE: begin
               done_o  = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         index_q     <= '0;
         pix_count_q <= '0;
         num_pix_q   <= '0;
         last_gray_q <= '0;
         thr_q       <= '0;
         mode_q      <= '0;
         pix_q       <= '0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         pix_count_q <= pix_count_d;
         num_pix_q   <= num_pix_d;
         last_gray_q <= last_gray_d;
         thr_q       <= thr_d;
         mode_q      <= mode_d;
         pix_q       <= pix_d;
         result_q    <= result_d;
      end
   end

   assign busy_o      = (state_q != S_IDLE);
   assign src_addr_o  = index_q[ADDR_BITS-1:0];
   assign dst_addr_o  = index_q[ADDR_BITS-1:0];
   assign dst_wdata_o = result_q;
   assign pix_count_o = pix_count_q;
   assign last_gray_o = last_gray_q;

endmodule

// File: tb/tb_pixel_filter_engine.sv
// Testbench for pixel_filter_engine: source RAM model with 1-cycle read
// latency, write scoreboard fed from a reference filter model, and one task
// per scenario. Cycle numbers are relative to the start-accept cycle (0).
module tb_pixel_filter_engine;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [7:0]  thr = 8'h00;
   logic [10:0] num_pix = 11'd0;
   logic [9:0]  src_addr, dst_addr;
   logic [23:0] src_rdata, dst_wdata;
   logic        dst_we, busy, done;
   logic [10:0] pix_count;
   logic [7:0]  last_gray;

   logic [23:0] src_mem [0:1023];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          t0 = 0;

   logic [23:0] exp_data [$];
   logic [9:0]  exp_addr [$];
   int          wr_cyc [$];
   logic [23:0] last_wdata = 24'h0;
   logic [23:0] mon_ed;
   logic [9:0]  mon_ea;

   pixel_filter_engine dut (
      .clk         (clk),
      .reset       (reset),
      .start_i     (start),
      .abort_i     (abort),
      .mode_i      (mode),
      .threshold_i (thr),
      .num_pix_i   (num_pix),
      .src_addr_o  (src_addr),
      .src_rdata_i (src_rdata),
      .dst_addr_o  (dst_addr),
      .dst_we_o    (dst_we),
      .dst_wdata_o (dst_wdata),
      .busy_o      (busy),
      .done_o      (done),
      .pix_count_o (pix_count),
      .last_gray_o (last_gray)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc       <= cyc + 1;
      src_rdata <= src_mem[src_addr];
   end

   // Scoreboard: every observed write pops and checks one expected write.
   always @(negedge clk) begin
      if (dst_we) begin
         wr_cyc.push_back(cyc - t0);
         last_wdata = dst_wdata;
         checks++;
         if (exp_data.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%h cycle=%0d", dst_addr, dst_wdata, cyc - t0);
         end else begin
            mon_ed = exp_data.pop_front();
            mon_ea = exp_addr.pop_front();
            if (dst_addr !== mon_ea || dst_wdata !== mon_ed) begin
               errors++;
               $display("FAIL write addr=%0d data=%h expected addr=%0d data=%h", dst_addr, dst_wdata, mon_ea, mon_ed);
            end
         end
      end
   end

   function automatic logic [23:0] model(input logic [1:0] m, input logic [7:0] th, input logic [23:0] p);
      int r, g, b, gy;
      logic [7:0] gy8;
      r = int'(p[23:16]);
      g = int'(p[15:8]);
      b = int'(p[7:0]);
      gy = (r + g + b) / 3;
      gy8 = gy[7:0];
      case (m)
         2'd0:    return p;
         2'd1:    return {gy8, gy8, gy8};
         2'd2:    return {8'(255 - r), 8'(255 - g), 8'(255 - b)};
         default: return (gy >= int'(th)) ? 24'hFFFFFF : 24'h000000;
      endcase
   endfunction

   // Drives one start pulse; the first n_exp pixels are expected to be written.
   task automatic start_job(input logic [1:0] m, input logic [7:0] th, input int n, input int n_exp);
      wr_cyc.delete();
      exp_data.delete();
      exp_addr.delete();
      for (int k = 0; k < n_exp; k++) begin
         exp_data.push_back(model(m, th, src_mem[k]));
         exp_addr.push_back(k[9:0]);
      end
      @(negedge clk);
      mode = m; thr = th; num_pix = n[10:0]; start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      // Scramble inputs: the job must use the latched copies.
      start = 1'b0; mode = ~m; thr = ~th; num_pix = 11'd5;
   endtask

   task automatic wait_done(input int n, output int done_rel);
      done_rel = -1;
      for (int i = 0; i < 4*n + 20; i++) begin
         if (done) begin
            done_rel = cyc - t0;
            break;
         end
         @(negedge clk);
      end
      if (done_rel >= 0) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, dst_we} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl busy/done/we=%b expected 000", {busy, done, dst_we});
      end
      checks++;
      if (src_addr !== 10'd0 || dst_addr !== 10'd0 || dst_wdata !== 24'd0) begin
         errors++; $display("FAIL reset_addr src=%0d dst=%0d wdata=%h expected 0", src_addr, dst_addr, dst_wdata);
      end
      checks++;
      if (pix_count !== 11'd0 || last_gray !== 8'd0) begin
         errors++; $display("FAIL reset_count pix_count=%0d last_gray=%h expected 0", pix_count, last_gray);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_copy();
      int d;
      src_mem[0] = 24'h102030; src_mem[1] = 24'hFFFFFF; src_mem[2] = 24'h000001;
      start_job(2'b00, 8'h00, 3, 3);
      wait_done(3, d);
      checks++;
      if (wr_cyc.size() != 3) begin
         errors++; $display("FAIL copy_nwrites got=%0d expected 3", wr_cyc.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (wr_cyc[k] != 4*k + 4) begin
               errors++; $display("FAIL copy_wr_cycle pix=%0d got=%0d expected %0d", k, wr_cyc[k], 4*k + 4);
            end
         end
      end
      checks++;
      if (d != 13) begin errors++; $display("FAIL copy_done_cycle got=%0d expected 13", d); end
      checks++;
      if (pix_count !== 11'd3 || busy !== 1'b0) begin
         errors++; $display("FAIL copy_end pix_count=%0d busy=%b expected 3/0", pix_count, busy);
      end
      checks++;
      if (exp_data.size() != 0) begin errors++; $display("FAIL copy_missing left=%0d expected 0", exp_data.size()); end
   endtask

   task automatic test_gray_thresh();
      int d;
      src_mem[0] = 24'h0A141E;
      start_job(2'b01, 8'h00, 1, 1);
      wait_done(1, d);
      checks++;
      if (last_wdata !== 24'h141414 || last_gray !== 8'h14) begin
         errors++; $display("FAIL gray data=%h gray=%h expected 141414/14", last_wdata, last_gray);
      end
      start_job(2'b11, 8'h14, 1, 1);
      wait_done(1, d);
      checks++;
      if (last_wdata !== 24'hFFFFFF) begin errors++; $display("FAIL thresh_eq data=%h expected ffffff", last_wdata); end
      start_job(2'b11, 8'h15, 1, 1);
      wait_done(1, d);
      checks++;
      if (last_wdata !== 24'h000000 || d != 5) begin
         errors++; $display("FAIL thresh_above data=%h done=%0d expected 000000/5", last_wdata, d);
      end
   endtask

   task automatic test_invert();
      int d;
      src_mem[0] = 24'h010000;
      start_job(2'b10, 8'h00, 1, 1);
      wait_done(1, d);
      checks++;
      if (last_wdata !== 24'hFEFFFF) begin errors++; $display("FAIL invert data=%h expected feffff", last_wdata); end
      start_job(2'b01, 8'h00, 1, 1);
      wait_done(1, d);
      checks++;
      if (last_wdata !== 24'h000000 || last_gray !== 8'h00) begin
         errors++; $display("FAIL gray_floor data=%h gray=%h expected 000000/00", last_wdata, last_gray);
      end
   endtask

   task automatic test_edge_counts();
      int d;
      start_job(2'b00, 8'h00, 0, 0);
      wait_done(0, d);
      checks++;
      if (d != 1 || wr_cyc.size() != 0) begin
         errors++; $display("FAIL zero_pix done=%0d writes=%0d expected 1/0", d, wr_cyc.size());
      end
      for (int i = 0; i < 1024; i++) src_mem[i] = 24'($urandom);
      start_job(2'($urandom_range(0, 3)), 8'($urandom), 1024, 1024);
      wait_done(1024, d);
      checks++;
      if (d != 4097) begin errors++; $display("FAIL full_done got=%0d expected 4097", d); end
      checks++;
      if (wr_cyc.size() != 1024 || exp_data.size() != 0 || pix_count !== 11'd1024) begin
         errors++;
         $display("FAIL full_count writes=%0d left=%0d pix_count=%0d expected 1024/0/1024", wr_cyc.size(), exp_data.size(), pix_count);
      end
   endtask

   task automatic test_abort();
      int ndone = 0;
      start_job(2'b00, 8'h00, 3, 1);
      while (cyc - t0 < 8) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(negedge clk);
      checks++;
      if (dst_we !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL abort_cycle we=%b busy=%b expected 0/1", dst_we, busy);
      end
      @(posedge clk); #1;
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b expected 0", busy); end
      repeat (16) begin
         @(negedge clk);
         if (done) ndone++;
      end
      checks++;
      if (ndone != 0 || pix_count !== 11'd1 || wr_cyc.size() != 1) begin
         errors++;
         $display("FAIL abort_after done=%0d pix_count=%0d writes=%0d expected 0/1/1", ndone, pix_count, wr_cyc.size());
      end
   endtask

   task automatic test_reset_mid();
      int ndone = 0;
      start_job(2'b00, 8'h00, 3, 3);
      while (cyc - t0 < 5) begin @(posedge clk); #1; end
      checks++;
      if (src_addr !== 10'd1 || busy !== 1'b1) begin
         errors++; $display("FAIL mid_read src_addr=%0d busy=%b expected 1/1", src_addr, busy);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || src_addr !== 10'd0 || pix_count !== 11'd0 || {done, dst_we} !== 2'b00 || dst_wdata !== 24'd0) begin
         errors++;
         $display("FAIL reset_async busy=%b src=%0d pix_count=%0d done/we=%b wdata=%h expected all 0", busy, src_addr, pix_count, {done, dst_we}, dst_wdata);
      end
      @(negedge clk);
      reset = 1'b0;
      exp_data.delete();
      exp_addr.delete();
      repeat (20) begin
         @(negedge clk);
         if (done) ndone++;
      end
      checks++;
      if (wr_cyc.size() != 1 || ndone != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_release writes=%0d done=%0d busy=%b expected 1/0/0", wr_cyc.size(), ndone, busy);
      end
   endtask

   task automatic test_restart();
      int d;
      src_mem[0] = 24'h123456; src_mem[1] = 24'h89ABCD;
      start_job(2'b00, 8'h00, 2, 2);
      @(negedge clk);
      start = 1'b1; mode = 2'b01; num_pix = 11'd1;
      @(negedge clk);
      start = 1'b0;
      wait_done(2, d);
      checks++;
      if (d != 9 || pix_count !== 11'd2 || exp_data.size() != 0) begin
         errors++;
         $display("FAIL busy_start done=%0d pix_count=%0d left=%0d expected 9/2/0", d, pix_count, exp_data.size());
      end
      start_job(2'b10, 8'h00, 1, 1);
      checks++;
      if (pix_count !== 11'd0) begin errors++; $display("FAIL restart_clear pix_count=%0d expected 0", pix_count); end
      wait_done(1, d);
      checks++;
      if (d != 5 || pix_count !== 11'd1 || last_wdata !== (24'hFFFFFF ^ src_mem[0])) begin
         errors++; $display("FAIL restart_mode done=%0d pix_count=%0d data=%h expected 5/1/%h", d, pix_count, last_wdata, 24'hFFFFFF ^ src_mem[0]);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) src_mem[i] = 24'h0;
      test_reset();
      test_copy();
      test_gray_thresh();
      test_invert();
      test_edge_counts();
      test_abort();
      test_reset_mid();
      test_restart();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pixel_filter_engine.md
PIXEL_FILTER_ENGINE -- requirements
Module: pixel_filter_engine

Interface
REQ-001 Parameter ADDR_BITS, default 10, width of both memory addresses.
REQ-002 Parameter CH_W, default 8, bits per colour channel; pixel width PIX_W = 3*CH_W.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a job; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of a running job.
REQ-007 mode  input  2  filter: 00 copy, 01 gray, 10 invert, 11 threshold.
REQ-008 threshold  input  CH_W  threshold level for mode 11.
REQ-009 num_pix  input  ADDR_BITS+1  pixel count; range 0..2^ADDR_BITS.
REQ-010 src_addr  output  ADDR_BITS  source RAM read address.
REQ-011 src_rdata  input  PIX_W  source RAM data; 1-cycle synchronous read latency.
REQ-012 dst_addr  output  ADDR_BITS  destination RAM write address.
REQ-013 dst_we  output  1  destination write enable.
REQ-014 dst_wdata  output  PIX_W  filtered pixel.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 pix_count  output  ADDR_BITS+1  pixels written in the current or last job.
REQ-018 last_gray  output  CH_W  gray value of the most recently written source pixel, for display.

Function
REQ-019 Pixel layout SHALL be R = [3CH_W-1:2CH_W], G = [2CH_W-1:CH_W], B = [CH_W-1:0].
REQ-020 FSM states SHALL be IDLE, READ, WAIT, FILTER, WRITE, DONE.
REQ-021 IDLE SHALL go to READ on start when num_pix > 0, and to DONE when num_pix = 0; otherwise it stays in IDLE.
REQ-022 On the cycle start is accepted, the block SHALL latch mode, threshold and num_pix, clear the index and pix_count, and ignore later changes to those inputs.
REQ-023 READ SHALL drive src_addr = index; WAIT SHALL capture src_rdata into a pixel register at the end of the cycle.
REQ-024 FILTER SHALL register the filtered result; the filter path SHALL be combinational from the pixel register.
REQ-025 WRITE SHALL assert dst_we for exactly one cycle, with dst_addr = index and dst_wdata = result.
REQ-026 In WRITE, pix_count and index SHALL increment; last_gray SHALL update.
REQ-027 WRITE SHALL go to DONE when index = num_pix-1, else to READ.
REQ-028 DONE SHALL assert done for one cycle and return to IDLE.
REQ-029 Timing, with the start-accept cycle as cycle 0: pixel k SHALL be written in cycle 4k+4, and done SHALL occur in cycle 4N+1; for N = 0, done SHALL occur in cycle 1 with no writes.
REQ-030 Gray SHALL be floor((R+G+B)/3), using a CH_W+2 bit sum; the result fits in CH_W bits.
REQ-031 Mode 00 SHALL output the pixel unchanged.
REQ-032 Mode 01 SHALL replicate gray into all three channels.
REQ-033 Mode 10 SHALL output (2^CH_W-1) minus each channel.
REQ-034 Mode 11 SHALL output all ones when gray >= threshold, else all zeros.
REQ-035 start SHALL be ignored while busy; no queueing.
REQ-036 abort while busy SHALL return the FSM to IDLE next cycle; dst_we SHALL be forced low in the abort cycle; no done pulse; pix_count SHALL hold its value.
REQ-037 Abort SHALL take precedence over all transitions; abort in IDLE has no effect.
REQ-038 For num_pix = 2^ADDR_BITS, the index SHALL cover 0..2^ADDR_BITS-1 with no wrap and no repeated write.
REQ-039 dst_we SHALL be low in all states other than WRITE.

Reset
REQ-040 Reset SHALL force state IDLE and zero the index, pix_count, last_gray, pixel and result registers, and all latched configuration.
REQ-041 During reset, busy, done and dst_we SHALL be 0, and src_addr, dst_addr and dst_wdata SHALL be 0.
REQ-042 Reset mid-job SHALL cancel the job immediately, asynchronously, with no further writes after release.

Verification
REQ-043 Copy: mode 00, num_pix 3, src = {0x102030, 0xFFFFFF, 0x000001} -> identical dst[0..2]; dst_we pulses at cycles 4, 8, 12; done at cycle 13; pix_count 3.
REQ-044 Gray/threshold: src[0] = 0x0A141E; mode 01 -> 0x141414; mode 11, threshold 0x14 -> 0xFFFFFF; threshold 0x15 -> 0x000000; last_gray 0x14.
REQ-045 Invert/rounding: src[0] = 0x010000, mode 10 -> 0xFEFFFF; mode 01 -> 0x000000 (floor 1/3).
REQ-046 Edge counts: num_pix 0 -> done at cycle 1, no dst_we; num_pix 1024 -> 1024 writes to addresses 0..1023, done at cycle 4097.
REQ-047 Abort/reset: abort in the WRITE cycle of pixel 1 -> no write of pixel 1, no done, pix_count 1, busy low next cycle; reset asserted mid-READ -> outputs 0 immediately.
REQ-048 Restart: start pulsed while busy -> ignored; a new start after done with mode changed -> new mode applied, pix_count restarts from 0.
